pipe_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage core.
- Drives the one-hot register-mux selects of the IF/ID, ID/EX and EX/MEM pipeline registers, plus the PC hold and EPC-redirect controls.
- Arbitrates between four hazard sources: CSR trap/mret redirect, branch/jump redirect, external memory stall, and load-use hazard.
- Also provides a post-reset pipeline purge, a stall watchdog and saturating performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and select encodings for the pipeline hazard controller.
// Also holds the load-use detection helper.
package pipe_ctrl_pkg;

  typedef logic [2:0] reg_sel_t;

  localparam reg_sel_t SEL_NORMAL = 3'b001;
  localparam reg_sel_t SEL_FLUSH  = 3'b010;
  localparam reg_sel_t SEL_STALL  = 3'b100;

  typedef enum logic [1:0] {BOOT, RUN, TRAP} ctrl_state_t;

  // A load in EX feeding a source operand of ID; x0 is never a real dependency.
  function automatic logic is_load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       use1,
    input logic [4:0] rs2,
    input logic       use2
  );
    return mem_read && (rd != 5'd0) &&
           ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and pipeline control outputs between the core datapath and
// the hazard controller. master = datapath side, slave = controller.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             use_rs1_ID;
  logic             use_rs2_ID;
  logic [4:0]       rd_EX;
  logic             mem_read_EX;
  logic             branch_taken_EX;
  logic             trap_req;
  logic             stall_ext;
  logic             clr_err;

  reg_sel_t         if_sel;
  reg_sel_t         id_sel;
  reg_sel_t         ex_sel;
  logic             pc_sel;
  logic             epc_taken;
  logic             pc_hold;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, mem_read_EX,
           branch_taken_EX, trap_req, stall_ext, clr_err,
    input  if_sel, id_sel, ex_sel, pc_sel, epc_taken, pc_hold,
           stall_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, mem_read_EX,
           branch_taken_EX, trap_req, stall_ext, clr_err,
    output if_sel, id_sel, ex_sel, pc_sel, epc_taken, pc_hold,
           stall_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage core: pipeline register selects,
// PC redirect/hold, stall watchdog and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int               RUN_W   = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(MAX_STALL - 1);

  ctrl_state_t      r_state;
  logic [RUN_W-1:0] r_stall_run;
  logic             r_stall_timeout;

  logic             w_load_use;
  logic             w_live;
  logic             w_row_trap;
  logic             w_row_br;
  logic             w_row_stall;
  logic             w_row_lu;
  reg_sel_t         w_if_sel;
  reg_sel_t         w_id_sel;
  reg_sel_t         w_ex_sel;
  logic             w_pc_sel;
  logic             w_epc_taken;
  logic             w_pc_hold;
  logic             w_wd_stall;
  logic             w_to_set;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  assign w_load_use = is_load_use(bus.mem_read_EX, bus.rd_EX,
                                  bus.rs1_ID, bus.use_rs1_ID,
                                  bus.rs2_ID, bus.use_rs2_ID);

  // Redirect requests are only trusted in RUN; in TRAP they come from flushed stages.
  assign w_live      = (r_state == RUN);
  assign w_row_trap  = w_live && bus.trap_req;
  assign w_row_br    = w_live && !bus.trap_req && bus.branch_taken_EX;
  assign w_row_stall = (r_state != BOOT) && !w_row_trap && !w_row_br && bus.stall_ext;
  assign w_row_lu    = (r_state != BOOT) && !w_row_trap && !w_row_br &&
                       !bus.stall_ext && w_load_use;

  always_comb begin
    w_if_sel    = SEL_NORMAL;
    w_id_sel    = SEL_NORMAL;
    w_ex_sel    = SEL_NORMAL;
    w_pc_sel    = 1'b0;
    w_epc_taken = 1'b0;
    w_pc_hold   = 1'b0;
    if (r_state == BOOT) begin
      w_if_sel  = SEL_FLUSH;
      w_id_sel  = SEL_FLUSH;
      w_ex_sel  = SEL_FLUSH;
      w_pc_hold = 1'b1;
    end else if (w_row_trap) begin
      w_if_sel    = SEL_FLUSH;
      w_id_sel    = SEL_FLUSH;
      w_ex_sel    = SEL_FLUSH;
      w_epc_taken = 1'b1;
    end else if (w_row_br) begin
      w_if_sel = SEL_FLUSH;
      w_id_sel = SEL_FLUSH;
      w_pc_sel = 1'b1;
    end else if (w_row_stall) begin
      w_if_sel  = SEL_STALL;
      w_id_sel  = SEL_STALL;
      w_ex_sel  = SEL_STALL;
      w_pc_hold = 1'b1;
    end else if (w_row_lu) begin
      // Hold IF/ID and inject a bubble into ID/EX so the load can complete.
      w_if_sel  = SEL_STALL;
      w_id_sel  = SEL_FLUSH;
      w_pc_hold = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
    end else begin
      case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     r_state <= w_row_trap ? TRAP : RUN;
        TRAP:    r_state <= RUN;
        default: r_state <= BOOT;
      endcase
    end
  end

  // Watchdog: timeout is raised on the cycle the run length reaches MAX_STALL.
  assign w_wd_stall = w_live && w_row_stall;
  assign w_to_set   = w_wd_stall && (r_stall_run >= RUN_PRE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_run     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      if (!w_wd_stall) begin
        r_stall_run <= '0;
      end else if (r_stall_run != RUN_MAX) begin
        r_stall_run <= r_stall_run + 1'b1;
      end
      if (w_to_set) begin
        r_stall_timeout <= 1'b1;
      end else if (bus.clr_err) begin
        r_stall_timeout <= 1'b0;
      end
    end
  end

  assign w_stall_inc = (r_state != BOOT) && w_pc_hold;
  assign w_flush_inc = w_row_trap || w_row_br;
  assign w_cnt_clr   = (r_state == BOOT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (w_stall_inc),
    .clr   (w_cnt_clr),
    .cnt   (w_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (w_flush_inc),
    .clr   (w_cnt_clr),
    .cnt   (w_flush_cnt)
  );

  assign bus.if_sel        = w_if_sel;
  assign bus.id_sel        = w_id_sel;
  assign bus.ex_sel        = w_ex_sel;
  assign bus.pc_sel        = w_pc_sel;
  assign bus.epc_taken     = w_epc_taken;
  assign bus.pc_hold       = w_pc_hold;
  assign bus.stall_timeout = r_stall_timeout;
  assign bus.stall_cnt     = w_stall_cnt;
  assign bus.flush_cnt     = w_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one full-size instance plus a small
// instance (CNT_W=4, MAX_STALL=8) fed the same inputs to reach saturation.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  // {if_sel, id_sel, ex_sel, pc_sel, epc_taken, pc_hold}
  localparam logic [11:0] CTL_BOOT = 12'b010_010_010_0_0_1;
  localparam logic [11:0] CTL_NORM = 12'b001_001_001_0_0_0;
  localparam logic [11:0] CTL_LU   = 12'b100_010_001_0_0_1;
  localparam logic [11:0] CTL_BR   = 12'b010_010_001_1_0_0;
  localparam logic [11:0] CTL_TRAP = 12'b010_010_010_0_1_0;
  localparam logic [11:0] CTL_STL  = 12'b100_100_100_0_0_1;

  logic clk;
  logic reset;
  int   vec;
  int   errs;

  pipe_hazard_ctrl_if #(.CNT_W(16)) a ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  b ();

  pipe_hazard_ctrl #(.MAX_STALL(64), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(a));
  pipe_hazard_ctrl #(.MAX_STALL(8),  .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(b));

  assign b.rs1_ID          = a.rs1_ID;
  assign b.rs2_ID          = a.rs2_ID;
  assign b.use_rs1_ID      = a.use_rs1_ID;
  assign b.use_rs2_ID      = a.use_rs2_ID;
  assign b.rd_EX           = a.rd_EX;
  assign b.mem_read_EX     = a.mem_read_EX;
  assign b.branch_taken_EX = a.branch_taken_EX;
  assign b.trap_req        = a.trap_req;
  assign b.stall_ext       = a.stall_ext;
  assign b.clr_err         = a.clr_err;

  logic [11:0] ctl;
  assign ctl = {a.if_sel, a.id_sel, a.ex_sel, a.pc_sel, a.epc_taken, a.pc_hold};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a.rs1_ID = 5'd0; a.rs2_ID = 5'd0; a.use_rs1_ID = 1'b0; a.use_rs2_ID = 1'b0;
    a.rd_EX = 5'd0; a.mem_read_EX = 1'b0; a.branch_taken_EX = 1'b0;
    a.trap_req = 1'b0; a.stall_ext = 1'b0; a.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    a.trap_req = 1'b1; a.stall_ext = 1'b1;
    #1;
    vec++; if (ctl !== CTL_BOOT) begin errs++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_BOOT); end
    vec++; if ({a.stall_cnt, a.flush_cnt, a.stall_timeout} !== 33'd0) begin errs++;
      $display("FAIL reset_regs: got %h/%h/%b want 0/0/0", a.stall_cnt, a.flush_cnt, a.stall_timeout); end
    reset = 1'b1;
    #1;
    vec++; if (ctl !== CTL_BOOT) begin errs++; $display("FAIL boot_ctl: got %b want %b", ctl, CTL_BOOT); end
    idle();
    step();
    vec++; if (ctl !== CTL_NORM) begin errs++; $display("FAIL run_ctl: got %b want %b", ctl, CTL_NORM); end
    vec++; if (a.stall_cnt !== 16'd0) begin errs++; $display("FAIL boot_nocount: got %0d want 0", a.stall_cnt); end
  endtask

  task automatic test_load_use();
    a.mem_read_EX = 1'b1; a.rd_EX = 5'd5; a.rs1_ID = 5'd5; a.use_rs1_ID = 1'b1;
    #1;
    vec++; if (ctl !== CTL_LU) begin errs++; $display("FAIL lu_rs1: got %b want %b", ctl, CTL_LU); end
    step();
    vec++; if (a.stall_cnt !== 16'd1) begin errs++; $display("FAIL lu_cnt1: got %0d want 1", a.stall_cnt); end
    a.mem_read_EX = 1'b0;
    #1;
    vec++; if (ctl !== CTL_NORM) begin errs++; $display("FAIL lu_after: got %b want %b", ctl, CTL_NORM); end
    step();
    a.mem_read_EX = 1'b1; a.rd_EX = 5'd7; a.rs1_ID = 5'd3; a.rs2_ID = 5'd7; a.use_rs2_ID = 1'b1;
    #1;
    vec++; if (ctl !== CTL_LU) begin errs++; $display("FAIL lu_rs2: got %b want %b", ctl, CTL_LU); end
    step();
    vec++; if (a.stall_cnt !== 16'd2) begin errs++; $display("FAIL lu_cnt2: got %0d want 2", a.stall_cnt); end
    a.rd_EX = 5'd0; a.rs1_ID = 5'd0; a.rs2_ID = 5'd0;
    #1;
    vec++; if (ctl !== CTL_NORM) begin errs++; $display("FAIL lu_x0: got %b want %b", ctl, CTL_NORM); end
    step();
    a.rd_EX = 5'd5; a.rs1_ID = 5'd5; a.use_rs1_ID = 1'b0; a.rs2_ID = 5'd9;
    #1;
    vec++; if (ctl !== CTL_NORM) begin errs++; $display("FAIL lu_nouse: got %b want %b", ctl, CTL_NORM); end
    step();
    a.mem_read_EX = 1'b0; a.use_rs1_ID = 1'b1;
    #1;
    vec++; if (ctl !== CTL_NORM) begin errs++; $display("FAIL lu_noload: got %b want %b", ctl, CTL_NORM); end
    step();
    vec++; if (a.stall_cnt !== 16'd2) begin errs++; $display("FAIL lu_cnt_hold: got %0d want 2", a.stall_cnt); end
    idle();
  endtask

  task automatic test_branch_vs_load_use();
    a.mem_read_EX = 1'b1; a.rd_EX = 5'd5; a.rs1_ID = 5'd5; a.use_rs1_ID = 1'b1;
    a.branch_taken_EX = 1'b1;
    #1;
    vec++; if (ctl !== CTL_BR) begin errs++; $display("FAIL br_lu: got %b want %b", ctl, CTL_BR); end
    step();
    vec++; if ({a.flush_cnt, a.stall_cnt} !== {16'd1, 16'd2}) begin errs++;
      $display("FAIL br_cnts: got flush %0d stall %0d want 1 2", a.flush_cnt, a.stall_cnt); end
    idle();
    #1;
    vec++; if (ctl !== CTL_NORM) begin errs++; $display("FAIL br_after: got %b want %b", ctl, CTL_NORM); end
    step();
  endtask

  task automatic test_trap();
    a.trap_req = 1'b1; a.branch_taken_EX = 1'b1;
    #1;
    vec++; if (ctl !== CTL_TRAP) begin errs++; $display("FAIL trap_row: got %b want %b", ctl, CTL_TRAP); end
    step();
    vec++; if (ctl !== CTL_NORM) begin errs++; $display("FAIL trap_mask: got %b want %b", ctl, CTL_NORM); end
    vec++; if (a.flush_cnt !== 16'd2) begin errs++; $display("FAIL trap_cnt: got %0d want 2", a.flush_cnt); end
    step();
    vec++; if (a.flush_cnt !== 16'd2) begin errs++; $display("FAIL trap_mask_cnt: got %0d want 2", a.flush_cnt); end
    a.trap_req = 1'b0;
    #1;
    vec++; if (ctl !== CTL_BR) begin errs++; $display("FAIL trap_back_run: got %b want %b", ctl, CTL_BR); end
    step();
    a.branch_taken_EX = 1'b0; a.trap_req = 1'b1;
    #1;
    vec++; if (ctl !== CTL_TRAP) begin errs++; $display("FAIL trap_row2: got %b want %b", ctl, CTL_TRAP); end
    step();
    a.trap_req = 1'b0; a.stall_ext = 1'b1;
    #1;
    vec++; if (ctl !== CTL_STL) begin errs++; $display("FAIL trap_stall: got %b want %b", ctl, CTL_STL); end
    step();
    vec++; if ({a.flush_cnt, a.stall_cnt} !== {16'd4, 16'd3}) begin errs++;
      $display("FAIL trap_cnts: got flush %0d stall %0d want 4 3", a.flush_cnt, a.stall_cnt); end
    idle();
    #1;
    vec++; if (ctl !== CTL_NORM) begin errs++; $display("FAIL trap_end: got %b want %b", ctl, CTL_NORM); end
    step();
  endtask

  task automatic test_stall_watchdog();
    a.stall_ext = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      #1;
      vec++; if (ctl !== CTL_STL) begin errs++; $display("FAIL stall_sel c%0d: got %b want %b", i, ctl, CTL_STL); end
      vec++; if (a.stall_timeout !== 1'b0) begin errs++; $display("FAIL wd_early c%0d: got 1 want 0", i); end
      vec++; if (b.stall_timeout !== (i > 8)) begin errs++;
        $display("FAIL wd_small c%0d: got %b want %b", i, b.stall_timeout, (i > 8)); end
      step();
    end
    a.stall_ext = 1'b0;
    #1;
    vec++; if (a.stall_timeout !== 1'b1) begin errs++; $display("FAIL wd_fire: got 0 want 1"); end
    vec++; if (a.stall_cnt !== 16'd67) begin errs++; $display("FAIL stall_cnt67: got %0d want 67", a.stall_cnt); end
    vec++; if (b.stall_cnt !== 4'd15) begin errs++; $display("FAIL stall_sat: got %0d want 15", b.stall_cnt); end
    a.clr_err = 1'b1;
    step();
    a.clr_err = 1'b0;
    vec++; if ({a.stall_timeout, b.stall_timeout} !== 2'b00) begin errs++;
      $display("FAIL wd_clr: got %b%b want 00", a.stall_timeout, b.stall_timeout); end
    a.clr_err = 1'b1; a.stall_ext = 1'b1;
    repeat (8) step();
    a.stall_ext = 1'b0;
    #1;
    vec++; if ({a.stall_timeout, b.stall_timeout} !== 2'b01) begin errs++;
      $display("FAIL wd_setwins: got %b%b want 01", a.stall_timeout, b.stall_timeout); end
    vec++; if (a.stall_cnt !== 16'd75) begin errs++; $display("FAIL stall_cnt75: got %0d want 75", a.stall_cnt); end
    step();
    a.clr_err = 1'b0;
    vec++; if (b.stall_timeout !== 1'b0) begin errs++; $display("FAIL wd_clr2: got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    a.branch_taken_EX = 1'b1;
    repeat (16) step();
    a.branch_taken_EX = 1'b0;
    #1;
    vec++; if (a.flush_cnt !== 16'd20) begin errs++; $display("FAIL flush20: got %0d want 20", a.flush_cnt); end
    vec++; if (b.flush_cnt !== 4'd15) begin errs++; $display("FAIL flush_sat: got %0d want 15", b.flush_cnt); end
    vec++; if (b.stall_cnt !== 4'd15) begin errs++; $display("FAIL stall_nowrap: got %0d want 15", b.stall_cnt); end
  endtask

  task automatic test_reset_mid();
    a.stall_ext = 1'b1;
    step();
    #2;
    reset = 1'b0;
    #1;
    vec++; if (ctl !== CTL_BOOT) begin errs++; $display("FAIL rst_midstall: got %b want %b", ctl, CTL_BOOT); end
    vec++; if ({a.stall_cnt, a.flush_cnt} !== 32'd0) begin errs++;
      $display("FAIL rst_cnts: got %0d/%0d want 0/0", a.stall_cnt, a.flush_cnt); end
    reset = 1'b1;
    idle();
    repeat (2) step();
    a.trap_req = 1'b1;
    #1;
    vec++; if (ctl !== CTL_TRAP) begin errs++; $display("FAIL rst_pretrap: got %b want %b", ctl, CTL_TRAP); end
    step();
    #1;
    reset = 1'b0;
    #1;
    vec++; if (ctl !== CTL_BOOT) begin errs++; $display("FAIL rst_midtrap: got %b want %b", ctl, CTL_BOOT); end
    idle();
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_trap();
    test_stall_watchdog();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
